input_port_sampler: RTL and testbench

Input-port front end for the TD4 datapath. It synchronises and debounces the 4-bit external input switches and presents a stable value on the `Im` bus, which the A and B registers load during IN instructions. It flags each newly committed value with a sticky VALID until the datapath reads it, and flags a lost value with OVR. It is the producing end of the register `Im` interface, and its read strobe follows the active-low LOAD convention.

---
 rtl/input_port_sampler_if.sv | 39 +++
 rtl/input_port_sampler.sv | 156 +++++++++++++++
 tb/tb_input_port_sampler.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_port_sampler_if.sv
// ---------------------------------------------------------------------------
// input_port_sampler_if
//
// Register Im bus between the input-port sampler (producer) and the A/B
// register load logic (consumer).
//
//   Out   : committed, debounced input value (drives Im)
//   VALID : sticky flag, a new value has been committed since the last read
//   OVR   : sticky flag, a committed value was overwritten before being read
//   RD    : active-low read strobe, driven by the consuming register's LOAD
//
// Modports:
//   master : the sampler, which drives Out/VALID/OVR and observes RD
//   slave  : the consumer, which observes Out/VALID/OVR and drives RD
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface input_port_sampler_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] Out;
    logic             VALID;
    logic             OVR;
    logic             RD;

    modport master (
        output Out,
        output VALID,
        output OVR,
        input  RD
    );

    modport slave (
        input  Out,
        input  VALID,
        input  OVR,
        output RD
    );
endinterface

// File: rtl/input_port_sampler.sv
// ---------------------------------------------------------------------------
// input_port_sampler
//
// Input-port front end for the TD4 datapath. The raw switch inputs are
// passed through a two-flop synchroniser, then debounced: a new value must
// be seen on DEBOUNCE_CYCLES consecutive synchronised samples before it is
// committed to Out. Each commit raises a sticky VALID; a commit on top of an
// unread value raises a sticky OVR. A read (RD low at a rising edge) clears
// both flags.
//
// Parameters:
//   WIDTH           : width of PIN and Out
//   DEBOUNCE_CYCLES : consecutive stable samples needed to commit (>= 2)
//
// Ports:
//   CLK : clock, rising edge
//   CLR : asynchronous, active-low reset
//   EN  : debounce enable; when low the FSM, candidate, counter and Out hold
//   PIN : raw asynchronous switch inputs
//   im  : Im bus (master side): Out, VALID, OVR driven here, RD observed
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module input_port_sampler #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  EN,
    input  logic [WIDTH-1:0]      PIN,
    input_port_sampler_if.master  im
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] cand_q,  cand_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic             valid_q, valid_d;
    logic             ovr_q,   ovr_d;

    logic             commit;
    logic             read;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        sync1_d = PIN;
        sync2_d = sync1_q;
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        commit  = 1'b0;

        if (EN) begin
            unique case (state_q)
                ST_STABLE: begin
                    if (sync2_q != out_q) begin
                        cand_d  = sync2_q;
                        cnt_d   = '0;
                        state_d = ST_SETTLING;
                    end
                end

                ST_SETTLING: begin
                    if (sync2_q != cand_q) begin
                        // Input moved again: restart the stability window.
                        cand_d = sync2_q;
                        cnt_d  = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        // Window complete. A candidate equal to Out means
                        // the input bounced back, so nothing is committed.
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                        if (cand_q != out_q) begin
                            out_d  = cand_q;
                            commit = 1'b1;
                        end
                    end
                end

                default: state_d = ST_STABLE;
            endcase
        end

        read = ~im.RD;

        // A commit always leaves VALID set, even alongside a read: the read
        // consumes the previous value and the new one remains pending.
        if (commit)
            valid_d = 1'b1;
        else if (read)
            valid_d = 1'b0;
        else
            valid_d = valid_q;

        // A read wins over an overrun at the same edge, since the value that
        // would have been lost has just been consumed.
        if (read)
            ovr_d = 1'b0;
        else if (commit && valid_q)
            ovr_d = 1'b1;
        else
            ovr_d = ovr_q;
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: all state here is a handful of flops, so every one of them is
    // cleared by the asynchronous reset; nothing is left to power-up value.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= ST_STABLE;
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, e.g. sync2 takes the old sync1, not PIN.
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign im.Out   = out_q;
    assign im.VALID = valid_q;
    assign im.OVR   = ovr_q;

endmodule

// File: tb/tb_input_port_sampler.sv
`timescale 1ns/1ps

module tb_input_port_sampler;

    localparam int WIDTH = 4;
    localparam int N     = 4;

    logic             CLK;
    logic             CLR;
    logic             EN;
    logic [WIDTH-1:0] PIN;

    int tests_run = 0;
    int fails     = 0;

    input_port_sampler_if #(.WIDTH(WIDTH)) im ();

    input_port_sampler #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .CLK (CLK),
        .CLR (CLR),
        .EN  (EN),
        .PIN (PIN),
        .im  (im.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge and settle 1 ns past it; inputs driven now are
    // set up for the next edge, outputs read now reflect this edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hold reset for two edges with the given PIN, then release 1 ns after
    // an edge. That edge is edge 0; the next one is edge 1.
    task automatic do_reset(input logic [WIDTH-1:0] pin_v);
        CLR   = 1'b0;
        EN    = 1'b1;
        im.RD = 1'b1;
        PIN   = pin_v;
        tick();
        tick();
        CLR = 1'b1;
    endtask

    // Reset values appear with no clock; release lets PIN=F commit at edge 7.
    task automatic test_reset();
        logic [5:0] obs;
        logic [5:0] exp;
        CLR   = 1'b0;
        EN    = 1'b1;
        im.RD = 1'b1;
        PIN   = 4'hF;
        #2;
        obs = {im.Out, im.VALID, im.OVR};
        exp = {4'h0, 1'b0, 1'b0};
        tests_run++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL reset_async: got %h expected %h", obs, exp);
        end
        tick();
        tick();
        CLR = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            obs = {im.Out, im.VALID, im.OVR};
            exp = (e < 7) ? {4'h0, 1'b0, 1'b0} : {4'hF, 1'b1, 1'b0};
            tests_run++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL reset_release edge %0d: got %h expected %h", e, obs, exp);
            end
        end
    endtask

    // 0x0 -> 0xA before edge 1 commits on edge 7, not edge 6.
    task automatic test_clean_step();
        logic [5:0] obs;
        do_reset(4'h0);
        PIN = 4'hA;
        for (int e = 1; e <= 6; e++) tick();
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL clean_step_edge6: got %h expected %h", obs, {4'h0, 1'b0, 1'b0});
        end
        tick();
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'hA, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL clean_step_edge7: got %h expected %h", obs, {4'hA, 1'b1, 1'b0});
        end
    endtask

    // Two-sample glitch of 0x5 is rejected; a held 0x5 commits 7 edges later.
    task automatic test_bounce();
        logic [5:0] obs;
        do_reset(4'h0);
        PIN = 4'h5;
        tick();
        tick();
        PIN = 4'h0;
        for (int e = 3; e <= 10; e++) begin
            tick();
            obs = {im.Out, im.VALID, im.OVR};
            tests_run++;
            if (obs !== {4'h0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL bounce_glitch edge %0d: got %h expected %h", e, obs, {4'h0, 1'b0, 1'b0});
            end
        end
        PIN = 4'h5;
        for (int e = 1; e <= 6; e++) tick();
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL bounce_edge6: got %h expected %h", obs, {4'h0, 1'b0, 1'b0});
        end
        tick();
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h5, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL bounce_edge7: got %h expected %h", obs, {4'h5, 1'b1, 1'b0});
        end
    endtask

    // Read clears VALID and keeps Out; read at a commit edge leaves VALID set.
    task automatic test_read();
        logic [5:0] obs;
        do_reset(4'h0);
        PIN = 4'hA;
        for (int e = 1; e <= 7; e++) tick();
        im.RD = 1'b0;
        tick();
        im.RD = 1'b1;
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'hA, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL read_clear: got %h expected %h", obs, {4'hA, 1'b0, 1'b0});
        end
        PIN = 4'h3;
        for (int e = 1; e <= 6; e++) tick();
        im.RD = 1'b0;
        tick();
        im.RD = 1'b1;
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h3, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL read_at_commit: got %h expected %h", obs, {4'h3, 1'b1, 1'b0});
        end
    endtask

    // Second commit without a read sets OVR; read clears both; read at an
    // overrunning commit edge keeps OVR clear.
    task automatic test_overrun();
        logic [5:0] obs;
        do_reset(4'h0);
        PIN = 4'h1;
        for (int e = 1; e <= 7; e++) tick();
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL overrun_first: got %h expected %h", obs, {4'h1, 1'b1, 1'b0});
        end
        PIN = 4'h2;
        for (int e = 1; e <= 7; e++) tick();
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h2, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL overrun_set: got %h expected %h", obs, {4'h2, 1'b1, 1'b1});
        end
        im.RD = 1'b0;
        tick();
        im.RD = 1'b1;
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h2, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL overrun_read: got %h expected %h", obs, {4'h2, 1'b0, 1'b0});
        end
        PIN = 4'h4;
        for (int e = 1; e <= 7; e++) tick();
        PIN = 4'h8;
        for (int e = 1; e <= 6; e++) tick();
        im.RD = 1'b0;
        tick();
        im.RD = 1'b1;
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h8, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL overrun_read_at_commit: got %h expected %h", obs, {4'h8, 1'b1, 1'b0});
        end
    endtask

    // EN low after edge 5 (cnt=2) freezes settling; two edges after EN
    // returns finish the window. Then CLR mid-SETTLING clears outputs at once.
    task automatic test_enable_and_reset();
        logic [5:0] obs;
        do_reset(4'h0);
        PIN = 4'h6;
        for (int e = 1; e <= 5; e++) tick();
        EN = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            obs = {im.Out, im.VALID, im.OVR};
            tests_run++;
            if (obs !== {4'h0, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL enable_frozen cycle %0d: got %h expected %h", e, obs, {4'h0, 1'b0, 1'b0});
            end
        end
        EN = 1'b1;
        tick();
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL enable_resume_1: got %h expected %h", obs, {4'h0, 1'b0, 1'b0});
        end
        tick();
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h6, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL enable_resume_2: got %h expected %h", obs, {4'h6, 1'b1, 1'b0});
        end

        PIN = 4'h9;
        for (int e = 1; e <= 4; e++) tick();
        CLR = 1'b0;
        #1;
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset_async: got %h expected %h", obs, {4'h0, 1'b0, 1'b0});
        end
        tick();
        tick();
        CLR = 1'b1;
        for (int e = 1; e <= 6; e++) tick();
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset_edge6: got %h expected %h", obs, {4'h0, 1'b0, 1'b0});
        end
        tick();
        obs = {im.Out, im.VALID, im.OVR};
        tests_run++;
        if (obs !== {4'h9, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL mid_reset_edge7: got %h expected %h", obs, {4'h9, 1'b1, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_read();
        test_overrun();
        test_enable_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
